// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: reads the framebuffer column by column,
// shifts upper/lower half colour bits per bit-plane, latches, and drives binary-weighted OE.
module hub75_scan_ctrl #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned HEIGHT  = 32,
    parameter int unsigned BPP     = 12,
    parameter int unsigned BPC     = 4,
    parameter int unsigned BASE_ON = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [13:0]    rd_addr,
    output logic           rd_en,
    input  logic [BPP-1:0] rd_data,
    output logic           sclk,
    output logic           lat,
    output logic           oe,
    output logic           a,
    output logic           b,
    output logic           c,
    output logic           d,
    output logic           e,
    output logic           r0,
    output logic           g0,
    output logic           b0,
    output logic           r1,
    output logic           g1,
    output logic           b1,
    output logic           frame_done
);

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned ROWS    = HEIGHT / 2;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned MAX_ON  = BASE_ON << (BPC - 1);
    localparam int unsigned CNT_W   = $clog2(MAX_ON + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_TOP   = 3'd1;
    localparam logic [2:0] RD_BOT   = 3'd2;
    localparam logic [2:0] SHIFT_LO = 3'd3;
    localparam logic [2:0] SHIFT_HI = 3'd4;
    localparam logic [2:0] LATCH    = 3'd5;
    localparam logic [2:0] DISPLAY  = 3'd6;

    logic [2:0]         state_q,      state_d;
    logic [ROW_W-1:0]   row_q,        row_d;
    logic [COL_W-1:0]   col_q,        col_d;
    logic [PLANE_W-1:0] plane_q,      plane_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [ADDR_W-1:0]  rd_addr_q,    rd_addr_d;
    logic               rd_en_q,      rd_en_d;
    logic               sclk_q,       sclk_d;
    logic               lat_q,        lat_d;
    logic               oe_q,         oe_d;
    logic [4:0]         scan_row_q,   scan_row_d;
    logic [2:0]         top_q,        top_d;
    logic [2:0]         bot_q,        bot_d;
    logic               frame_done_q, frame_done_d;

    logic [BPC-1:0] red_c;
    logic [BPC-1:0] grn_c;
    logic [BPC-1:0] blu_c;
    logic [2:0]     px_bits_c;

    // Current bit-plane slice of the word on the read bus, ordered {R,G,B}
    assign red_c     = rd_data[3*BPC-1 -: BPC];
    assign grn_c     = rd_data[2*BPC-1 -: BPC];
    assign blu_c     = rd_data[BPC-1 -: BPC];
    assign px_bits_c = {red_c[plane_q], grn_c[plane_q], blu_c[plane_q]};

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        plane_d      = plane_q;
        cnt_d        = cnt_q;
        rd_addr_d    = rd_addr_q;
        rd_en_d      = 1'b0;
        sclk_d       = 1'b0;
        lat_d        = 1'b0;
        oe_d         = 1'b1;
        scan_row_d   = scan_row_q;
        top_d        = top_q;
        bot_d        = bot_q;
        frame_done_d = 1'b0;

        // Output registers are loaded with the values belonging to the state being entered
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = RD_TOP;
                    row_d     = '0;
                    col_d     = '0;
                    plane_d   = '0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            RD_TOP: begin
                state_d   = RD_BOT;
                rd_en_d   = 1'b1;
                rd_addr_d = ADDR_W'((32'(row_q) + 32'(ROWS)) * 32'(WIDTH) + 32'(col_q));
            end
            RD_BOT: begin
                state_d = SHIFT_LO;
                top_d   = px_bits_c;
            end
            SHIFT_LO: begin
                state_d = SHIFT_HI;
                sclk_d  = 1'b1;
                bot_d   = px_bits_c;
            end
            SHIFT_HI: begin
                if (32'(col_q) < WIDTH - 1) begin
                    col_d     = col_q + COL_W'(1);
                    state_d   = RD_TOP;
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_W'(32'(row_q) * 32'(WIDTH) + 32'(col_d));
                end else begin
                    state_d    = LATCH;
                    lat_d      = 1'b1;
                    scan_row_d = row_q;
                end
            end
            LATCH: begin
                state_d = DISPLAY;
                oe_d    = 1'b0;
                cnt_d   = CNT_W'((32'(BASE_ON) << plane_q) - 32'd1);
            end
            DISPLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    oe_d  = 1'b0;
                end else begin
                    col_d   = '0;
                    state_d = RD_TOP;
                    rd_en_d = 1'b1;
                    // Plane advances first; the row only moves once every plane is shown
                    if (32'(plane_q) == BPC - 1) begin
                        plane_d = '0;
                        if (32'(row_q) == ROWS - 1) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            if (!en) begin
                                state_d = IDLE;
                                rd_en_d = 1'b0;
                            end
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        plane_d = plane_q + PLANE_W'(1);
                    end
                    rd_addr_d = ADDR_W'(32'(row_d) * 32'(WIDTH));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            plane_q      <= '0;
            cnt_q        <= '0;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            sclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_q         <= 1'b1;
            scan_row_q   <= '0;
            top_q        <= '0;
            bot_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            plane_q      <= plane_d;
            cnt_q        <= cnt_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_q      <= rd_en_d;
            sclk_q       <= sclk_d;
            lat_q        <= lat_d;
            oe_q         <= oe_d;
            scan_row_q   <= scan_row_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign rd_en      = rd_en_q;
    assign sclk       = sclk_q;
    assign lat        = lat_q;
    assign oe         = oe_q;
    assign {e, d, c, b, a} = scan_row_q;
    assign frame_done = frame_done_q;
    assign r0 = top_q[2];
    assign g0 = top_q[1];
    assign b0 = top_q[0];
    // The lower-half word only arrives during SHIFT_LO, so it is forwarded straight from the bus
    assign r1 = (state_q == SHIFT_LO) ? px_bits_c[2] : bot_q[2];
    assign g1 = (state_q == SHIFT_LO) ? px_bits_c[1] : bot_q[1];
    assign b1 = (state_q == SHIFT_LO) ? px_bits_c[0] : bot_q[0];

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl on a 4x4 panel, 2 bit-planes, BASE_ON=2.
module tb_hub75_scan_ctrl;

    localparam int unsigned W       = 4;
    localparam int unsigned H       = 4;
    localparam int unsigned BPP     = 6;
    localparam int unsigned BPC     = 2;
    localparam int unsigned BASE_ON = 2;
    localparam int          PERIOD  = 80;
    localparam int          NVEC    = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [13:0] rd_addr;
    logic        rd_en;
    logic [5:0]  rd_data;
    logic        sclk, lat, oe, a, b, c, d, e;
    logic        r0, g0, b0, r1, g1, b1, frame_done;

    logic [5:0] mem [16];

    int checks   = 0;
    int failures = 0;

    hub75_scan_ctrl #(
        .WIDTH(W), .HEIGHT(H), .BPP(BPP), .BPC(BPC), .BASE_ON(BASE_ON)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .sclk(sclk), .lat(lat), .oe(oe),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous framebuffer: data one clk after the strobe
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[3:0]];
    end

    typedef struct {
        logic        rd_en;
        logic [13:0] addr;
        logic        sclk;
        logic        lat;
        logic        oe;
        logic [4:0]  row;
        logic [5:0]  rgb;
        logic        chk_rgb;
    } vec_t;

    vec_t vt [NVEC];

    function automatic vec_t mk(logic re, int addr, logic s, logic l, logic o,
                                int row, logic [5:0] rgb, logic cr);
        vec_t v;
        v.rd_en = re; v.addr = 14'(addr); v.sclk = s; v.lat = l; v.oe = o;
        v.row = 5'(row); v.rgb = rgb; v.chk_rgb = cr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] outs_all();
        return {sclk, lat, oe, e, d, c, b, a, r0, g0, b0, r1, g1, b1, rd_en, rd_addr, frame_done};
    endfunction

    localparam logic [29:0] RESET_OUTS = {1'b0, 1'b0, 1'b1, 5'd0, 6'd0, 1'b0, 14'd0, 1'b0};

    // Background monitor: OE-low run lengths, row shown, frame_done times, lat sanity
    int  cyc = 0;
    bit  mon_en = 1'b0;
    int  run = 0;
    int  run_row = 0;
    int  runs[$];
    int  rows[$];
    int  fd_times[$];
    int  bad = 0;
    logic lat_prev = 1'b0;
    logic fd_prev  = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (!oe) begin
                run++;
                run_row = int'({e, d, c, b, a});
            end else if (run != 0) begin
                runs.push_back(run);
                rows.push_back(run_row);
                run = 0;
            end
            if (frame_done) fd_times.push_back(cyc);
            if (lat && !oe) bad++;
            if (lat && lat_prev) bad++;
            if (frame_done && fd_prev) bad++;
            lat_prev = lat;
            fd_prev  = frame_done;
        end
    end

    initial begin
        int t0;
        int budget;
        int wid;
        logic [5:0] rgb;
        int exp_w [4];
        int exp_r [4];

        exp_w = '{2, 4, 2, 4};
        exp_r = '{0, 0, 1, 1};

        for (int i = 0; i < 16; i++) mem[i] = 6'h00;
        mem[0]  = 6'h30; mem[8]  = 6'h03;
        mem[1]  = 6'h0C; mem[9]  = 6'h30;
        mem[2]  = 6'h15; mem[10] = 6'h2A;
        mem[3]  = 6'h00; mem[11] = 6'h3F;
        mem[4]  = 6'h2A; mem[12] = 6'h15;
        rd_data = 6'h00;

        // rgb = {r0,g0,b0,r1,g1,b1}; plane 0 of row 0
        vt[0]  = mk(1, 0,  0, 0, 1, 0, 6'b000_000, 0);
        vt[1]  = mk(1, 8,  0, 0, 1, 0, 6'b000_000, 0);
        vt[2]  = mk(0, 0,  0, 0, 1, 0, 6'b100_001, 1);
        vt[3]  = mk(0, 0,  1, 0, 1, 0, 6'b100_001, 1);
        vt[4]  = mk(1, 1,  0, 0, 1, 0, 6'b000_000, 0);
        vt[5]  = mk(1, 9,  0, 0, 1, 0, 6'b000_000, 0);
        vt[6]  = mk(0, 0,  0, 0, 1, 0, 6'b010_100, 1);
        vt[7]  = mk(0, 0,  1, 0, 1, 0, 6'b010_100, 1);
        vt[8]  = mk(1, 2,  0, 0, 1, 0, 6'b000_000, 0);
        vt[9]  = mk(1, 10, 0, 0, 1, 0, 6'b000_000, 0);
        vt[10] = mk(0, 0,  0, 0, 1, 0, 6'b111_000, 1);
        vt[11] = mk(0, 0,  1, 0, 1, 0, 6'b111_000, 1);
        vt[12] = mk(1, 3,  0, 0, 1, 0, 6'b000_000, 0);
        vt[13] = mk(1, 11, 0, 0, 1, 0, 6'b000_000, 0);
        vt[14] = mk(0, 0,  0, 0, 1, 0, 6'b000_111, 1);
        vt[15] = mk(0, 0,  1, 0, 1, 0, 6'b000_111, 1);
        vt[16] = mk(0, 0,  0, 1, 1, 0, 6'b000_000, 0);
        vt[17] = mk(0, 0,  0, 0, 0, 0, 6'b000_000, 0);
        vt[18] = mk(0, 0,  0, 0, 0, 0, 6'b000_000, 0);
        vt[19] = mk(1, 0,  0, 0, 1, 0, 6'b000_000, 0);

        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(outs_all()), 32'(RESET_OUTS));
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_without_en", {29'd0, rd_en, oe, sclk}, {29'd0, 1'b0, 1'b1, 1'b0});

        // Start scanning and walk the first row/plane cycle by cycle
        mon_en = 1'b1;
        #1 t0 = cyc;
        en = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rgb = {r0, g0, b0, r1, g1, b1};
            chk($sformatf("vec%0d", i),
                {rd_en, (vt[i].rd_en ? rd_addr : 14'd0), sclk, lat, oe, e, d, c, b, a,
                 (vt[i].chk_rgb ? rgb : 6'd0)},
                {vt[i].rd_en, vt[i].addr, vt[i].sclk, vt[i].lat, vt[i].oe, vt[i].row,
                 (vt[i].chk_rgb ? vt[i].rgb : 6'd0)});
        end

        budget = 0;
        while (fd_times.size() < 2 && budget < 300) begin
            @(negedge clk); #1;
            budget++;
        end
        chk("two_frames_seen", 32'(fd_times.size() >= 2), 32'd1);
        if (fd_times.size() >= 2) begin
            chk("first_frame_done_time", 32'(fd_times[0] - t0), 32'(PERIOD + 1));
            chk("frame_period", 32'(fd_times[1] - fd_times[0]), 32'(PERIOD));
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("oe_low_width%0d", k), (runs.size() > k) ? 32'(runs[k]) : 32'hFFFF_FFFF, 32'(exp_w[k]));
            chk($sformatf("display_row%0d", k),  (rows.size() > k) ? 32'(rows[k]) : 32'hFFFF_FFFF, 32'(exp_r[k]));
        end

        // Drop en mid-frame: frame must complete, then the block idles blanked
        repeat (20) @(negedge clk);
        en = 1'b0;
        budget = 0;
        while (fd_times.size() < 3 && budget < 200) begin
            @(negedge clk); #1;
            budget++;
        end
        chk("frame_after_en_drop", (fd_times.size() >= 3) ? 32'(fd_times[2] - fd_times[1]) : 32'd0, 32'(PERIOD));
        wid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_en || !oe || sclk || lat || frame_done) wid++;
        end
        chk("idle_after_drop", 32'(wid), 32'd0);
        chk("lat_oe_fd_sanity", 32'(bad), 32'd0);

        // Reset asserted while OE is low
        en = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (oe && budget < 100);
        chk("reach_display", {31'd0, oe}, 32'd0);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1 chk("reset_mid_display", 32'(outs_all()), 32'(RESET_OUTS));
        repeat (2) @(negedge clk);
        chk("held_in_reset", 32'(outs_all()), 32'(RESET_OUTS));
        #2 rst = 1'b1;
        @(negedge clk);
        chk("restart_first_read", {17'd0, rd_en, rd_addr}, {17'd0, 1'b1, 14'd0});
        @(negedge clk);
        chk("restart_second_read", {17'd0, rd_en, rd_addr}, {17'd0, 1'b1, 14'd8});
        budget = 0;
        while (oe && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        wid = 0;
        while (!oe && wid < 20) begin
            wid++;
            @(negedge clk);
        end
        chk("restart_plane0_width", 32'(wid), 32'(BASE_ON));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
